// File: rtl/spi_bus_arbiter_if.sv
// Requester and SPI-engine signals of spi_bus_arbiter.
// slave = arbiter view, master = core/engine view.
interface spi_bus_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic        i_err;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_size;
  logic        d_ready;
  logic        d_err;
  logic [31:0] d_rdata;

  logic        eng_start;
  logic        eng_sel;
  logic        eng_we;
  logic [23:0] eng_addr;
  logic [31:0] eng_wdata;
  logic [1:0]  eng_size;
  logic        eng_done;
  logic [31:0] eng_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_size, eng_done, eng_rdata,
    output i_ready, i_err, i_rdata, d_ready, d_err, d_rdata,
           eng_start, eng_sel, eng_we, eng_addr, eng_wdata, eng_size
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_size, eng_done, eng_rdata,
    input  i_ready, i_err, i_rdata, d_ready, d_err, d_rdata,
           eng_start, eng_sel, eng_we, eng_addr, eng_wdata, eng_size
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Shares one quad-SPI engine between the fetch and data ports, with flash/PSRAM decode
// and a chip-select gap. Define SPI_ARB_FAIRNESS_EN to bound how long a fetch can starve.
module spi_bus_arbiter #(
  parameter logic [31:0] FLASH_BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] PSRAM_BASE_ADDR = 32'h0100_0000,
  parameter int unsigned CS_GAP_CYCLES   = 2,
  parameter int unsigned MAX_DATA_RUN    = 4
) (
  input logic              clk,
  input logic              rst,
  spi_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  localparam logic [3:0] GAP_LAST = 4'(CS_GAP_CYCLES - 1);

  if (CS_GAP_CYCLES < 1 || CS_GAP_CYCLES > 15 || MAX_DATA_RUN < 1 || MAX_DATA_RUN > 15) begin : g_bad_param
    $error("spi_bus_arbiter: CS_GAP_CYCLES and MAX_DATA_RUN must be 1..15");
  end

  state_t      state, state_nxt;
  logic [3:0]  gap_cnt;

  // Transaction owned by the engine; held from ISSUE until the next grant.
  logic        own_d, sel_q, we_q;
  logic [23:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;

  logic        i_ready_q, i_err_q, d_ready_q, d_err_q;
  logic [31:0] i_rdata_q, d_rdata_q;

  logic        arb_en, pick_d, win_we, hit_flash, hit_psram, win_err, run_full;
  logic [31:0] win_addr;

`ifdef SPI_ARB_FAIRNESS_EN
  logic [3:0]  run_cnt;
  assign run_full = (run_cnt == 4'(MAX_DATA_RUN));
`else
  assign run_full = 1'b0;
`endif

  // Arbitration is held off while a response pulse is out, so a requester
  // that has not yet dropped its req is not served twice.
  assign arb_en = (state == IDLE) && (bus.i_req || bus.d_req) && !i_ready_q && !d_ready_q;

  // NOTE: every signal written here gets a value on every path first; a missed
  // assignment in a combinational block infers a latch.
  always_comb begin
    pick_d    = bus.d_req && !(run_full && bus.i_req);
    win_addr  = pick_d ? bus.d_addr : bus.i_addr;
    win_we    = pick_d && bus.d_we;
    hit_flash = (win_addr[31:24] == FLASH_BASE_ADDR[31:24]);
    hit_psram = (win_addr[31:24] == PSRAM_BASE_ADDR[31:24]);
    win_err   = !(hit_flash || hit_psram) || (win_we && hit_flash);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (arb_en && !win_err) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (bus.eng_done) state_nxt = GAP;
      GAP:     if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the latched transaction fields are reset as well, because they drive
  // eng_* outputs directly and must read 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      own_d     <= 1'b0;
      sel_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      i_ready_q <= 1'b0;
      i_err_q   <= 1'b0;
      i_rdata_q <= '0;
      d_ready_q <= 1'b0;
      d_err_q   <= 1'b0;
      d_rdata_q <= '0;
`ifdef SPI_ARB_FAIRNESS_EN
      run_cnt   <= '0;
`endif
    end else begin
      state     <= state_nxt;
      gap_cnt   <= (state == GAP && state_nxt == GAP) ? gap_cnt + 4'd1 : 4'd0;
      i_ready_q <= 1'b0;
      i_err_q   <= 1'b0;
      d_ready_q <= 1'b0;
      d_err_q   <= 1'b0;

      if (arb_en) begin
        if (win_err) begin
          // Decode errors answer directly without touching the engine.
          if (pick_d) begin
            d_ready_q <= 1'b1;
            d_err_q   <= 1'b1;
            d_rdata_q <= '0;
          end else begin
            i_ready_q <= 1'b1;
            i_err_q   <= 1'b1;
            i_rdata_q <= '0;
          end
        end else begin
          own_d   <= pick_d;
          sel_q   <= !hit_flash;
          we_q    <= win_we;
          addr_q  <= win_addr[23:0];
          wdata_q <= pick_d ? bus.d_wdata : 32'h0;
          size_q  <= pick_d ? bus.d_size : 2'd2;
`ifdef SPI_ARB_FAIRNESS_EN
          if (!pick_d || !bus.i_req) run_cnt <= '0;
          else if (!run_full)        run_cnt <= run_cnt + 4'd1;
`endif
        end
      end

      if (state == WAIT && bus.eng_done) begin
        if (own_d) begin
          d_ready_q <= 1'b1;
          d_rdata_q <= bus.eng_rdata;
        end else begin
          i_ready_q <= 1'b1;
          i_rdata_q <= bus.eng_rdata;
        end
      end
    end
  end

  always_comb begin
    bus.eng_start = (state == ISSUE);
    bus.eng_sel   = sel_q;
    bus.eng_we    = we_q;
    bus.eng_addr  = addr_q;
    bus.eng_wdata = wdata_q;
    bus.eng_size  = size_q;
    bus.i_ready   = i_ready_q;
    bus.i_err     = i_err_q;
    bus.i_rdata   = i_rdata_q;
    bus.d_ready   = d_ready_q;
    bus.d_err     = d_err_q;
    bus.d_rdata   = d_rdata_q;
  end
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: expected engine commands and responses are queued
// as requests are driven and popped as the DUT produces them.
module tb_spi_bus_arbiter;
  localparam int GAP     = 3;
  localparam int MAX_RUN = 4;

  typedef struct packed {
    logic        sel;
    logic        we;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
  } cmd_t;

  typedef struct packed {
    logic        port_d;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_bus_arbiter_if bus ();

  spi_bus_arbiter #(
    .CS_GAP_CYCLES(GAP),
    .MAX_DATA_RUN (MAX_RUN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  cmd_t        exp_cmd[$];
  resp_t       exp_resp[$];
  logic [31:0] rdata_q[$];
  cmd_t        live_cmd;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int eng_cnt = 0;
  int eng_lat = 9;
  logic [31:0] eng_resp = '0;
  int n_start = 0, start_cyc = -1, done_cyc = -1, i_ready_cyc = -1, d_ready_cyc = -1;
  bit i_drop = 0, d_drop = 0, d_hold = 0, gap_chk = 0, eng_aborted = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t cur_cmd();
    cmd_t c;
    c.sel   = bus.eng_sel;
    c.we    = bus.eng_we;
    c.addr  = bus.eng_addr;
    c.wdata = bus.eng_we ? bus.eng_wdata : 32'h0;
    c.size  = bus.eng_size;
    return c;
  endfunction

  function automatic cmd_t mk_cmd(logic sel, logic we, logic [23:0] addr, logic [31:0] wdata,
                                  logic [1:0] size);
    cmd_t c;
    c.sel = sel; c.we = we; c.addr = addr; c.wdata = we ? wdata : 32'h0; c.size = size;
    return c;
  endfunction

  function automatic resp_t mk_resp(logic port_d, logic err, logic [31:0] rdata);
    resp_t r;
    r.port_d = port_d; r.err = err; r.rdata = rdata;
    return r;
  endfunction

  task automatic got_resp(logic port_d, logic err, logic [31:0] rdata);
    resp_t r;
    if (exp_resp.size() == 0) begin
      check(port_d ? "d_ready_unexpected" : "i_ready_unexpected", 64'(port_d ? bus.d_ready : bus.i_ready), 64'd0);
    end else begin
      r = exp_resp.pop_front();
      check(port_d ? "d_resp" : "i_resp", 64'({port_d, err, rdata}), 64'(r));
    end
    if (port_d) begin
      d_ready_cyc = cyc;
      if (!d_hold) d_drop = 1;
    end else begin
      i_ready_cyc = cyc;
      i_drop = 1;
    end
  endtask

  // One clock: sample outputs at the falling edge, run the engine model and
  // the requesters' drop-after-ready behaviour.
  task automatic step();
    cmd_t c;
    @(negedge clk);
    cyc++;
    if (i_drop) begin bus.i_req = 1'b0; i_drop = 0; end
    if (d_drop) begin bus.d_req = 1'b0; d_drop = 0; end
    bus.eng_done = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        bus.eng_done  = 1'b1;
        bus.eng_rdata = eng_resp;
        done_cyc      = cyc;
        if (!eng_aborted) check("eng_stable", 64'(cur_cmd()), 64'(live_cmd));
      end
    end
    if (bus.eng_start === 1'b1) begin
      c = cur_cmd();
      if (exp_cmd.size() == 0) begin
        check("eng_start_unexpected", 64'(bus.eng_start), 64'd0);
      end else begin
        live_cmd = exp_cmd.pop_front();
        check("eng_cmd", 64'(c), 64'(live_cmd));
      end
      if (gap_chk && done_cyc >= 0) check("gap_cycles", 64'(cyc - done_cyc), 64'(GAP + 2));
      eng_resp  = (rdata_q.size() != 0) ? rdata_q.pop_front() : 32'hDEAD_BEEF;
      eng_cnt   = eng_lat;
      start_cyc = cyc;
      n_start++;
    end
    if (bus.i_ready === 1'b1 && bus.d_ready === 1'b1) check("both_ready", 64'(bus.i_ready & bus.d_ready), 64'd0);
    if (bus.i_ready === 1'b1) got_resp(1'b0, bus.i_err, bus.i_rdata);
    if (bus.d_ready === 1'b1) got_resp(1'b1, bus.d_err, bus.d_rdata);
  endtask

  task automatic wait_resp(int max_cyc, string tag);
    int n = 0;
    while (exp_resp.size() != 0 && n < max_cyc) begin step(); n++; end
    check({tag, "_resp_drained"}, 64'(exp_resp.size()), 64'd0);
  endtask

  task automatic wait_quiet(int max_cyc, string tag);
    int n = 0;
    while ((exp_cmd.size() != 0 || exp_resp.size() != 0 || eng_cnt != 0 || i_drop || d_drop)
           && n < max_cyc) begin
      step(); n++;
    end
    check({tag, "_drained"}, 64'(exp_cmd.size() + exp_resp.size()), 64'd0);
    repeat (GAP + 2) step();
  endtask

  initial begin
    int req_c, s0;
    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_size = '0;
    bus.eng_done = 0; bus.eng_rdata = '0;

    // Reset values
    step();
    check("rst_pulses", 64'({bus.i_ready, bus.i_err, bus.d_ready, bus.d_err, bus.eng_start}), 64'd0);
    check("rst_rdata", 64'({bus.i_rdata, bus.d_rdata}), 64'd0);
    check("rst_eng", 64'(cur_cmd()), 64'd0);
    rst = 1'b0;
    step();

    // Fetch only: start at +1, done at +10, ready at +11
    eng_lat = 9;
    exp_cmd.push_back(mk_cmd(1'b0, 1'b0, 24'h000100, 32'h0, 2'd2));
    rdata_q.push_back(32'h0000_0013);
    exp_resp.push_back(mk_resp(1'b0, 1'b0, 32'h0000_0013));
    bus.i_addr = 32'h0000_0100; bus.i_req = 1'b1; req_c = cyc;
    wait_quiet(60, "fetch");
    check("fetch_start_lat", 64'(start_cyc - req_c), 64'd1);
    check("fetch_ready_lat", 64'(i_ready_cyc - req_c), 64'd11);
    check("fetch_rdata_held", 64'(bus.i_rdata), 64'h13);

    // Collision: data first, fetch only after the chip-select gap
    eng_lat = 4;
    exp_cmd.push_back(mk_cmd(1'b1, 1'b0, 24'h000020, 32'h0, 2'd2));
    exp_cmd.push_back(mk_cmd(1'b0, 1'b0, 24'h000200, 32'h0, 2'd2));
    rdata_q.push_back(32'h1111_2222); rdata_q.push_back(32'h3333_4444);
    exp_resp.push_back(mk_resp(1'b1, 1'b0, 32'h1111_2222));
    exp_resp.push_back(mk_resp(1'b0, 1'b0, 32'h3333_4444));
    bus.d_addr = 32'h0100_0020; bus.d_we = 1'b0; bus.d_size = 2'd2; bus.d_req = 1'b1;
    bus.i_addr = 32'h0000_0200; bus.i_req = 1'b1;
    wait_quiet(80, "collision");
    check("collision_fetch_gap", 64'(start_cyc - d_ready_cyc >= GAP + 1), 64'd1);

    // Data write to flash: error at +1, no engine start
    s0 = n_start;
    exp_resp.push_back(mk_resp(1'b1, 1'b1, 32'h0));
    bus.d_we = 1'b1; bus.d_addr = 32'h0000_0040; bus.d_wdata = 32'h5555_AAAA; bus.d_req = 1'b1;
    req_c = cyc;
    wait_quiet(20, "flash_wr_err");
    check("flash_wr_err_lat", 64'(d_ready_cyc - req_c), 64'd1);
    check("flash_wr_err_nostart", 64'(n_start), 64'(s0));

    // Fetch from an unmapped window
    exp_resp.push_back(mk_resp(1'b0, 1'b1, 32'h0));
    bus.i_addr = 32'h2000_0000; bus.i_req = 1'b1; req_c = cyc;
    wait_quiet(20, "fetch_err");
    check("fetch_err_lat", 64'(i_ready_cyc - req_c), 64'd1);
    check("fetch_err_nostart", 64'(n_start), 64'(s0));

    // Half-word read from flash, then byte write to PSRAM
    eng_lat = 2;
    exp_cmd.push_back(mk_cmd(1'b0, 1'b0, 24'h000044, 32'h0, 2'd1));
    rdata_q.push_back(32'h0000_BEEF);
    exp_resp.push_back(mk_resp(1'b1, 1'b0, 32'h0000_BEEF));
    bus.d_we = 1'b0; bus.d_addr = 32'h0000_0044; bus.d_size = 2'd1; bus.d_req = 1'b1;
    wait_quiet(40, "flash_rd");
    exp_cmd.push_back(mk_cmd(1'b1, 1'b1, 24'hABCDEF, 32'h0000_00A5, 2'd0));
    rdata_q.push_back(32'h0);
    exp_resp.push_back(mk_resp(1'b1, 1'b0, 32'h0));
    bus.d_we = 1'b1; bus.d_addr = 32'h01AB_CDEF; bus.d_wdata = 32'h0000_00A5; bus.d_size = 2'd0;
    bus.d_req = 1'b1;
    wait_quiet(40, "psram_wr");

    // Starvation: data held continuously alongside a fetch
    eng_lat = 3;
    d_hold  = 1;
    bus.d_we = 1'b0; bus.d_addr = 32'h0100_0400; bus.d_size = 2'd2;
    bus.i_addr = 32'h0000_0500;
`ifdef SPI_ARB_FAIRNESS_EN
    for (int k = 0; k < MAX_RUN; k++) begin
      exp_cmd.push_back(mk_cmd(1'b1, 1'b0, 24'h000400, 32'h0, 2'd2));
      rdata_q.push_back(32'h0D00_0000 + 32'(k));
      exp_resp.push_back(mk_resp(1'b1, 1'b0, 32'h0D00_0000 + 32'(k)));
    end
    exp_cmd.push_back(mk_cmd(1'b0, 1'b0, 24'h000500, 32'h0, 2'd2));
    rdata_q.push_back(32'h0F00_0013);
    exp_resp.push_back(mk_resp(1'b0, 1'b0, 32'h0F00_0013));
    bus.d_req = 1'b1; bus.i_req = 1'b1;
    wait_resp(200, "fair");
    bus.d_req = 1'b0; d_hold = 0;
    wait_quiet(40, "fair");
`else
    for (int k = 0; k < 6; k++) begin
      exp_cmd.push_back(mk_cmd(1'b1, 1'b0, 24'h000400, 32'h0, 2'd2));
      rdata_q.push_back(32'h0D00_0000 + 32'(k));
      exp_resp.push_back(mk_resp(1'b1, 1'b0, 32'h0D00_0000 + 32'(k)));
    end
    bus.d_req = 1'b1; bus.i_req = 1'b1;
    wait_resp(200, "strict");
    bus.d_req = 1'b0; d_hold = 0;
    check("strict_fetch_waiting", 64'(bus.i_req), 64'd1);
    exp_cmd.push_back(mk_cmd(1'b0, 1'b0, 24'h000500, 32'h0, 2'd2));
    rdata_q.push_back(32'h0F00_0013);
    exp_resp.push_back(mk_resp(1'b0, 1'b0, 32'h0F00_0013));
    wait_quiet(60, "strict");
`endif

    // Reset while in WAIT: no response, stray done ignored, then normal service
    eng_lat = 8;
    exp_cmd.push_back(mk_cmd(1'b1, 1'b0, 24'h000080, 32'h0, 2'd2));
    rdata_q.push_back(32'h0000_0077);
    bus.d_we = 1'b0; bus.d_addr = 32'h0100_0080; bus.d_size = 2'd2; bus.d_req = 1'b1;
    s0 = n_start;
    for (int n = 0; n < 10 && n_start == s0; n++) step();
    check("rst_wait_started", 64'(n_start), 64'(s0 + 1));
    step(); step();
    rst = 1'b1; bus.d_req = 1'b0; eng_aborted = 1;
    step();
    rst = 1'b0;
    check("rst_wait_pulses", 64'({bus.i_ready, bus.d_ready, bus.eng_start}), 64'd0);
    check("rst_wait_eng", 64'(cur_cmd()), 64'd0);
    s0 = d_ready_cyc;
    for (int n = 0; n < 20 && eng_cnt != 0; n++) step();
    repeat (4) step();
    check("rst_wait_no_ready", 64'(d_ready_cyc), 64'(s0));
    eng_aborted = 0;
    exp_cmd.push_back(mk_cmd(1'b0, 1'b0, 24'h000300, 32'h0, 2'd2));
    rdata_q.push_back(32'h0000_0099);
    exp_resp.push_back(mk_resp(1'b0, 1'b0, 32'h0000_0099));
    bus.i_addr = 32'h0000_0300; bus.i_req = 1'b1; req_c = cyc;
    wait_quiet(60, "post_rst");
    check("post_rst_start_lat", 64'(start_cyc - req_c), 64'd1);

    // Back-to-back PSRAM writes: exact gap between done and next start
    eng_lat  = 5;
    done_cyc = -1;
    gap_chk  = 1;
    d_hold   = 1;
    for (int k = 0; k < 3; k++) begin
      exp_cmd.push_back(mk_cmd(1'b1, 1'b1, 24'h000010, 32'hCAFE_F00D, 2'd2));
      rdata_q.push_back(32'h0);
      exp_resp.push_back(mk_resp(1'b1, 1'b0, 32'h0));
    end
    bus.d_we = 1'b1; bus.d_addr = 32'h0100_0010; bus.d_wdata = 32'hCAFE_F00D; bus.d_size = 2'd2;
    bus.d_req = 1'b1;
    wait_resp(120, "gap");
    bus.d_req = 1'b0; d_hold = 0; gap_chk = 0;
    wait_quiet(40, "gap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule
